// File: rtl/vid_pkg.sv
// Shared video-memory definitions: port widths, 6-bit glyph codes and the hex nibble glyph map.
package vid_pkg;

  localparam int VID_ADDR_W = 11;
  localparam int VID_DATA_W = 18;

  typedef logic [5:0] glyph_t;

  // Codes 1..16 are the hex digits; flag glyphs sit just above them.
  localparam glyph_t GLYPH_BLANK  = 6'd0;
  localparam glyph_t GLYPH_FLAG_C = 6'd17;
  localparam glyph_t GLYPH_FLAG_Z = 6'd18;
  localparam glyph_t GLYPH_FLAG_N = 6'd19;
  localparam glyph_t GLYPH_FLAG_V = 6'd20;
  localparam glyph_t GLYPH_FLAG_I = 6'd21;

  function automatic glyph_t glyph_of_nibble(input logic [3:0] nib);
    return glyph_t'({2'b00, nib} + 6'd1);
  endfunction

endpackage

// File: rtl/vid_wr_fifo.sv
// Generic sync FIFO with a combinational head word; flags decode a registered count.
// A push while full is dropped even if a pop happens in the same cycle.
module vid_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vid_mem_write_sched.sv
// Port-1 write scheduler: debug-snapshot renderer and host queue, round-robin arbitrated during blank.
// Grant to write is one cycle; host_ready = !full; a write caught by a blank fall is held and reissued.
module vid_mem_write_sched
  import vid_pkg::*;
#(
  parameter int NUM_FIELDS = 25,
  parameter int FIELD_BASE = 341,
  parameter int ROW_STRIDE = 27,
  parameter int ADDR_W     = VID_ADDR_W,
  parameter int DATA_W     = VID_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              blank,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [4:0]        field_sel,
  input  logic [15:0]       field_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              snap_busy,
  output logic              snap_done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WR_HI, S_WR_LO} snap_state_t;

  localparam int         QW       = ADDR_W + DATA_W;
  localparam logic [4:0] LAST_IDX = 5'(NUM_FIELDS - 1);

  snap_state_t       state;
  logic              blank_q;
  logic              rr_host;
  logic              we_q;
  logic              last_q;
  logic [ADDR_W-1:0] fld_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [15:0]       fld_val;
  logic [QW-1:0]     q_head;
  logic              q_full;
  logic              q_empty;
  logic              snap_req;
  logic              host_req;
  logic              gnt_snap;
  logic              gnt_host;
  logic              wr_done;
  logic [DATA_W-1:0] word_hi;
  logic [DATA_W-1:0] word_lo;

  vid_wr_fifo #(
    .WIDTH (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_host_q (
    .CLK      (CLK),
    .CLR      (CLR),
    .push     (host_valid),
    .push_dat ({host_addr, host_data}),
    .pop      (gnt_host),
    .pop_dat  (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign host_ready = !q_full;

  assign word_hi = DATA_W'({6'd0, glyph_of_nibble(fld_val[15:12]), glyph_of_nibble(fld_val[11:8])});
  assign word_lo = DATA_W'({glyph_of_nibble(fld_val[7:4]), glyph_of_nibble(fld_val[3:0]), 6'd0});

  // Lone requester wins outright; on contention rr_host picks the side.
  assign snap_req = blank && ((state == S_WR_HI) || (state == S_WR_LO));
  assign host_req = blank && !q_empty;
  assign gnt_snap = snap_req && (!host_req || !rr_host);
  assign gnt_host = host_req && (!snap_req || rr_host);

  assign wr_done  = we_q && blank;
  assign mem_we   = wr_done;
  assign mem_addr = blank ? addr_q : pix_addr;
  assign mem_din  = din_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= S_IDLE;
      blank_q   <= 1'b0;
      field_sel <= '0;
      fld_addr  <= ADDR_W'(FIELD_BASE);
      fld_val   <= '0;
      rr_host   <= 1'b0;
      we_q      <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      snap_busy <= 1'b0;
      snap_done <= 1'b0;
    end else begin
      blank_q   <= blank;
      snap_done <= wr_done && last_q;

      if (blank && !blank_q && (state == S_IDLE)) snap_busy <= 1'b1;
      else if (wr_done && last_q)                  snap_busy <= 1'b0;

      // With blank low nothing is granted and a pending write stays parked.
      if (blank) begin
        we_q   <= gnt_snap || gnt_host;
        last_q <= gnt_snap && (state == S_WR_LO) && (field_sel == LAST_IDX);

        if (gnt_snap) begin
          addr_q <= (state == S_WR_HI) ? fld_addr : fld_addr + ADDR_W'(1);
          din_q  <= (state == S_WR_HI) ? word_hi : word_lo;
        end else if (gnt_host) begin
          addr_q <= q_head[QW-1:DATA_W];
          din_q  <= q_head[DATA_W-1:0];
        end

        if (gnt_snap)      rr_host <= 1'b1;
        else if (gnt_host) rr_host <= 1'b0;

        case (state)
          S_IDLE: begin
            if (!blank_q) begin
              state     <= S_FETCH;
              field_sel <= '0;
              fld_addr  <= ADDR_W'(FIELD_BASE);
            end
          end
          S_FETCH: begin
            fld_val <= field_data;
            state   <= S_WR_HI;
          end
          S_WR_HI: begin
            if (gnt_snap) state <= S_WR_LO;
          end
          S_WR_LO: begin
            if (gnt_snap) begin
              if (field_sel == LAST_IDX) begin
                state     <= S_IDLE;
                field_sel <= '0;
              end else begin
                state     <= S_FETCH;
                field_sel <= field_sel + 5'd1;
                fld_addr  <= fld_addr + ADDR_W'(ROW_STRIDE);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vid_mem_write_sched.sv
// Directed bench for vid_mem_write_sched with a 3-field snapshot and hand-computed glyph words.
module tb_vid_mem_write_sched;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        blank;
  logic [10:0] pix_addr;
  logic [4:0]  field_sel;
  logic [15:0] field_data;
  logic        host_valid;
  logic        host_ready;
  logic [10:0] host_addr;
  logic [17:0] host_data;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [17:0] mem_din;
  logic        snap_busy;
  logic        snap_done;

  logic [15:0] fv [3];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int bad_we = 0;
  logic [10:0] log_a [$];
  logic [17:0] log_d [$];
  logic [10:0] exp_a [$];
  logic [17:0] exp_d [$];

  typedef struct {
    logic        blank;
    logic [10:0] pix;
    logic        we;
    logic [10:0] addr;
    logic [17:0] din;
    logic        busy;
    logic        done;
    logic [4:0]  sel;
  } vec_t;

  always #5 CLK = ~CLK;

  assign field_data = (field_sel < 5'd3) ? fv[field_sel[1:0]] : 16'hDEAD;

  vid_mem_write_sched #(
    .NUM_FIELDS (3)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .blank      (blank),
    .pix_addr   (pix_addr),
    .field_sel  (field_sel),
    .field_data (field_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .snap_busy  (snap_busy),
    .snap_done  (snap_done)
  );

  always @(negedge CLK) begin
    if (mem_we) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_din);
    end
    if (mem_we && !blank) bad_we++;
    if (snap_done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    blank = 1'b0;
    host_valid = 1'b0;
    @(posedge CLK);
    #1;
    CLR = 1'b1;
  endtask

  task automatic add_exp(input logic [10:0] a, input logic [17:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic check_log(input string nm, input int base);
    chk({nm, "_count"}, 32'(log_a.size() - base), 32'(exp_a.size()));
    if (log_a.size() - base == exp_a.size())
      for (int i = 0; i < exp_a.size(); i++)
        chk($sformatf("%s_w%0d", nm, i), {3'b0, log_a[base+i], log_d[base+i]},
            {3'b0, exp_a[i], exp_d[i]});
  endtask

  function automatic vec_t mk(input logic b, input logic [10:0] p, input logic we,
                              input logic [10:0] a, input logic [17:0] d, input logic bz,
                              input logic dn, input logic [4:0] s);
    vec_t v;
    v.blank = b; v.pix = p; v.we = we; v.addr = a; v.din = d; v.busy = bz; v.done = dn; v.sel = s;
    return v;
  endfunction

  initial begin
    vec_t tbl [16];
    int base;
    int d0;

    fv[0] = 16'h00AF;
    fv[1] = 16'h1234;
    fv[2] = 16'hFFFF;

    // Cycle-by-cycle uncontended snapshot: 3 cycles per field, done one cycle after last write.
    tbl[0]  = mk(1'b0, 11'h123, 1'b0, 11'h123, 18'h0,     1'b0, 1'b0, 5'd0);
    tbl[1]  = mk(1'b0, 11'h7FF, 1'b0, 11'h7FF, 18'h0,     1'b0, 1'b0, 5'd0);
    tbl[2]  = mk(1'b1, 11'h000, 1'b0, 11'd0,   18'h0,     1'b0, 1'b0, 5'd0);
    tbl[3]  = mk(1'b1, 11'h000, 1'b0, 11'd0,   18'h0,     1'b1, 1'b0, 5'd0);
    tbl[4]  = mk(1'b1, 11'h000, 1'b0, 11'd0,   18'h0,     1'b1, 1'b0, 5'd0);
    tbl[5]  = mk(1'b1, 11'h000, 1'b1, 11'd341, 18'h00041, 1'b1, 1'b0, 5'd0);
    tbl[6]  = mk(1'b1, 11'h000, 1'b1, 11'd342, 18'h0B400, 1'b1, 1'b0, 5'd1);
    tbl[7]  = mk(1'b1, 11'h000, 1'b0, 11'd0,   18'h0,     1'b1, 1'b0, 5'd1);
    tbl[8]  = mk(1'b1, 11'h000, 1'b1, 11'd368, 18'h00083, 1'b1, 1'b0, 5'd1);
    tbl[9]  = mk(1'b1, 11'h000, 1'b1, 11'd369, 18'h04140, 1'b1, 1'b0, 5'd2);
    tbl[10] = mk(1'b1, 11'h000, 1'b0, 11'd0,   18'h0,     1'b1, 1'b0, 5'd2);
    tbl[11] = mk(1'b1, 11'h000, 1'b1, 11'd395, 18'h00410, 1'b1, 1'b0, 5'd2);
    tbl[12] = mk(1'b1, 11'h000, 1'b1, 11'd396, 18'h10400, 1'b1, 1'b0, 5'd0);
    tbl[13] = mk(1'b1, 11'h000, 1'b0, 11'd0,   18'h0,     1'b0, 1'b1, 5'd0);
    tbl[14] = mk(1'b1, 11'h000, 1'b0, 11'd0,   18'h0,     1'b0, 1'b0, 5'd0);
    tbl[15] = mk(1'b0, 11'h055, 1'b0, 11'h055, 18'h0,     1'b0, 1'b0, 5'd0);

    CLR = 1'b0;
    blank = 1'b0;
    pix_addr = 11'h123;
    host_valid = 1'b0;
    host_addr = 11'h0;
    host_data = 18'h0;

    @(posedge CLK);
    #1;
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 11'h123);
    chk("rst_din", mem_din, 18'h0);
    chk("rst_ready", host_ready, 1'b1);
    chk("rst_busy", snap_busy, 1'b0);
    chk("rst_done", snap_done, 1'b0);
    chk("rst_sel", field_sel, 5'd0);
    @(posedge CLK);
    #1;
    CLR = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step();
      blank = tbl[i].blank;
      pix_addr = tbl[i].pix;
      @(negedge CLK);
      chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].we);
      if (!tbl[i].blank || tbl[i].we) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      if (tbl[i].we) chk($sformatf("tbl%0d_din", i), mem_din, tbl[i].din);
      chk($sformatf("tbl%0d_busy", i), snap_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), snap_done, tbl[i].done);
      chk($sformatf("tbl%0d_sel", i), field_sel, tbl[i].sel);
    end

    // Blank falls while the WR_HI write is in flight; it is reissued, nothing skipped or doubled.
    exp_a.delete();
    exp_d.delete();
    add_exp(11'd341, 18'h00041);
    add_exp(11'd342, 18'h0B400);
    add_exp(11'd368, 18'h00083);
    add_exp(11'd369, 18'h04140);
    add_exp(11'd395, 18'h00410);
    add_exp(11'd396, 18'h10400);
    do_reset();
    base = log_a.size();
    d0 = done_cnt;
    step(); blank = 1'b1;
    step();
    step();
    step(); blank = 1'b0; pix_addr = 11'h321;
    @(negedge CLK);
    chk("drop_we_low", mem_we, 1'b0);
    chk("drop_addr_pix", mem_addr, 11'h321);
    step();
    step();
    step(); blank = 1'b1;
    @(negedge CLK);
    chk("drop_resume_we", mem_we, 1'b1);
    chk("drop_resume_addr", mem_addr, 11'd341);
    repeat (15) step();
    check_log("drop", base);
    chk("drop_done", 32'(done_cnt - d0), 32'd1);
    chk("drop_busy_end", snap_busy, 1'b0);

    // Second blank rise while parked in FETCH of field 1 must not restart the snapshot.
    do_reset();
    base = log_a.size();
    d0 = done_cnt;
    step(); blank = 1'b1;
    repeat (3) step();
    step(); blank = 1'b0;
    @(negedge CLK);
    chk("retrig_sel", field_sel, 5'd1);
    step();
    step(); blank = 1'b1;
    repeat (30) step();
    check_log("retrig", base);
    chk("retrig_done", 32'(done_cnt - d0), 32'd1);

    // Reset asserted while a write is on the port.
    do_reset();
    step(); blank = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    chk("rstw_we_before", mem_we, 1'b1);
    #1;
    CLR = 1'b0;
    #1;
    chk("rstw_we", mem_we, 1'b0);
    chk("rstw_busy", snap_busy, 1'b0);
    chk("rstw_sel", field_sel, 5'd0);
    chk("rstw_ready", host_ready, 1'b1);
    blank = 1'b0;
    pix_addr = 11'h123;
    #1;
    chk("rstw_addr", mem_addr, 11'h123);
    chk("rstw_din", mem_din, 18'h0);
    base = log_a.size();
    step(); CLR = 1'b1;
    repeat (5) step();
    chk("rstw_no_write", 32'(log_a.size() - base), 32'd0);

    // Host writes arriving mid-snapshot interleave snapshot/host/snapshot/host.
    exp_a.delete();
    exp_d.delete();
    add_exp(11'd341, 18'h00041);
    add_exp(11'h7F0, 18'h3FFFF);
    add_exp(11'd342, 18'h0B400);
    add_exp(11'h000, 18'h12345);
    add_exp(11'd368, 18'h00083);
    add_exp(11'd369, 18'h04140);
    add_exp(11'd395, 18'h00410);
    add_exp(11'd396, 18'h10400);
    do_reset();
    base = log_a.size();
    step(); blank = 1'b1;
    step(); host_valid = 1'b1; host_addr = 11'h7F0; host_data = 18'h3FFFF;
    step(); host_addr = 11'h000; host_data = 18'h12345;
    step(); host_valid = 1'b0;
    repeat (20) step();
    check_log("ilv", base);

    // Fill the queue in active video, refuse a fifth push, then drain in order during blank.
    exp_a.delete();
    exp_d.delete();
    add_exp(11'h010, 18'h00001);
    add_exp(11'h011, 18'h00002);
    add_exp(11'd341, 18'h00041);
    add_exp(11'h012, 18'h00003);
    add_exp(11'd342, 18'h0B400);
    add_exp(11'h013, 18'h00004);
    add_exp(11'd368, 18'h00083);
    add_exp(11'd369, 18'h04140);
    add_exp(11'd395, 18'h00410);
    add_exp(11'd396, 18'h10400);
    do_reset();
    base = log_a.size();
    for (int k = 0; k < 4; k++) begin
      step();
      host_valid = 1'b1;
      host_addr = 11'(16 + k);
      host_data = 18'(k + 1);
    end
    step(); host_addr = 11'h014; host_data = 18'h00005;
    @(negedge CLK);
    chk("full_ready_low", host_ready, 1'b0);
    chk("full_no_drain", mem_we, 1'b0);
    step(); host_valid = 1'b0; blank = 1'b1;
    @(negedge CLK);
    chk("full_ready_still_low", host_ready, 1'b0);
    step();
    @(negedge CLK);
    chk("full_ready_back", host_ready, 1'b1);
    repeat (20) step();
    check_log("full", base);

    chk("no_we_in_active", 32'(bad_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
